dmem_hs: RTL and testbench
==========================

Name: dmem_hs

Overview:
- Parametrised data memory for the core, replacing the single-cycle combinational dmem model.
- Adds a valid/ready request channel, a response channel with backpressure, and byte-lane write strobes.
- Adds configurable wait-state latency and error reporting for out-of-range or misaligned accesses.
- Sits between the core's load/store path and the testbench top, alongside imem.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, minimum 4.
- LATENCY, 1, cycles from request accept to response valid; legal range 1..8.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be DEPTH_WORDS*4 aligned.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- reqValid  in  1  request present.
- reqReady  out  1  block can accept a request.
- reqAddr  in  32  byte address.
- reqWen  in  1  1 = store, 0 = load.
- reqWdata  in  32  store data, lane-aligned.
- reqBe  in  4  byte enables; bit i enables byte lane i; must be nonzero for stores.
- rspValid  out  1  response present.
- rspReady  in  1  consumer accepts response.
- rspRdata  out  32  load data (full word; core does extraction); 0 for stores and errors.
- rspErr  out  1  access fault.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; reqReady=0 while asserted, 1 from first clock after release.
  - rspValid=0, rspRdata=0, rspErr=0, latency counter=0.
  - Memory array contents are not reset.
- FSM states are IDLE, WAIT, RESP.
- IDLE:
  - reqReady=1.
  - On reqValid&&reqReady, latch addr/wen/wdata/be into request registers and load cnt=LATENCY-1.
  - Go to WAIT if LATENCY>1, else RESP.
- WAIT:
  - reqReady=0; cnt decrements each cycle.
  - At cnt==1, go to RESP next cycle.
  - Total accept-to-rspValid = LATENCY cycles.
- Error check, evaluated at accept:
  - err = (addr < BASE_ADDR) || (addr >= BASE_ADDR+DEPTH_WORDS*4) || (addr[1:0] != 0) || (wen && be==0).
  - Word index = (addr-BASE_ADDR)>>2, width $clog2(DEPTH_WORDS).
- Memory access on the clock edge entering RESP:
  - Store without err: write only the enabled lanes.
  - Load without err: register the full word into rspRdata.
  - With err: no write; rspRdata=0.
- RESP:
  - rspValid=1; rspErr, rspRdata held stable until rspValid&&rspReady.
  - On handshake, return to IDLE; rspValid drops the next cycle.
  - reqReady=0 in RESP, so there is one outstanding request max.
  - Minimum request spacing is LATENCY+1 cycles.
- Load of a word stored earlier returns the new data: read-after-write is ordered by the single outstanding request.
- reqValid while reqReady=0 is ignored; the requester must hold the request stable.
- Reset asserted mid-transaction:
  - Aborts immediately; pending store not performed if the RESP edge has not occurred.
  - Outputs return to reset values.
- rspReady held low keeps RESP indefinitely with no change to outputs (no timeout).

Decomposition:
- Package dmem_pkg holds:
  - typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;
  - localparams WORD_W=32, BE_W=4;
  - typedef struct packed {addr, wen, wdata, be} dmem_req_t.
- Sub-module dmem_array:
  - Synchronous single-port array, DEPTH_WORDS x 32.
  - Per-byte write enable; registered read; enable input.
- dmem_hs holds the FSM, counter, error logic and output registers.

Test Plan:
- Reset release, LATENCY=1: store 0xDEADBEEF @0x10, be=4'hF -> rspValid 1 cycle after accept, rspErr=0. Then load @0x10 -> rspRdata=0xDEADBEEF.
- Byte lanes: word 0x11223344 @0x20, then store 0x0000AA00 be=4'b0010 -> load returns 0x1122AA44.
- LATENCY=4: load accepted at cycle t -> rspValid at t+4; reqReady low t+1..t+4; a second reqValid held during that window is accepted only after the response handshake.
- Errors:
  - Load @0x13 (misaligned) -> rspErr=1, rspRdata=0.
  - Store @DEPTH_WORDS*4 -> rspErr=1, and the word at 0x0 is unchanged on readback.
  - Store with be=0 -> rspErr=1.
- Backpressure: rspReady=0 for 5 cycles in RESP -> rspValid, rspRdata, rspErr stable throughout; handshake on cycle 6 -> IDLE, reqReady=1 the next cycle.
- Reset mid-WAIT (LATENCY=4, store 0xCAFEF00D @0x30 over a prior 0x12345678): assert rst at cycle 2 -> outputs zero asynchronously; load after release returns 0x12345678.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the handshaked data memory: FSM states and the latched request record.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic              wen;
    logic [WORD_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } dmem_req_t;

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word array with per-byte write enables and a registered read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
  logic [WORD_W-1:0] rdata_q;

  // Storage and read register are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < BE_W; i++) begin
          if (be_i[i]) begin
            mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_hs.sv
// Data memory with valid/ready request and response channels, byte strobes,
// configurable wait states and fault reporting for out-of-range/misaligned accesses.
module dmem_hs
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [31:0] reqAddr,
  input  logic        reqWen,
  input  logic [31:0] reqWdata,
  input  logic [3:0]  reqBe,
  output logic        rspValid,
  input  logic        rspReady,
  output logic [31:0] rspRdata,
  output logic        rspErr
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT    = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
  localparam bit          SINGLE   = (LATENCY == 1);

  dmem_state_t state_q, state_d;
  dmem_req_t   req_q, req_d;
  logic        err_q, err_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rdy_q, rdy_d;

  logic              accept_s;
  logic              err_now_s;
  logic              mem_en_s;
  logic              mem_wen_s;
  logic [31:0]       mem_addr_s;
  logic [31:0]       mem_wdata_s;
  logic [3:0]        mem_be_s;
  logic [31:0]       mem_off_s;
  logic [31:0]       arr_rdata_s;
  logic              unused_ok_s;

  assign accept_s  = reqValid && rdy_q;
  assign err_now_s = ({1'b0, reqAddr} < {1'b0, BASE_ADDR}) ||
                     ({1'b0, reqAddr} >= LIMIT) ||
                     (reqAddr[1:0] != 2'b00) ||
                     (reqWen && (reqBe == 4'b0000));

  // With LATENCY=1 the array access shares the accept edge, so it must see the live request.
  assign mem_addr_s  = (state_q == IDLE) ? reqAddr  : req_q.addr;
  assign mem_wen_s   = (state_q == IDLE) ? reqWen   : req_q.wen;
  assign mem_wdata_s = (state_q == IDLE) ? reqWdata : req_q.wdata;
  assign mem_be_s    = (state_q == IDLE) ? reqBe    : req_q.be;
  assign mem_en_s    = (SINGLE && accept_s && !err_now_s) ||
                       ((state_q == WAIT) && (cnt_q == 4'd1) && !err_q);
  assign mem_off_s   = mem_addr_s - BASE_ADDR;
  assign unused_ok_s = ^{mem_off_s[31:AW+2], mem_off_s[1:0]};

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk    (clk),
    .en_i   (mem_en_s),
    .we_i   (mem_wen_s),
    .be_i   (mem_be_s),
    .addr_i (mem_off_s[AW+1:2]),
    .wdata_i(mem_wdata_s),
    .rdata_o(arr_rdata_s)
  );

  // Next-state, request latch and wait-state counter.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          req_d.addr  = reqAddr;
          req_d.wen   = reqWen;
          req_d.wdata = reqWdata;
          req_d.be    = reqBe;
          err_d       = err_now_s;
          cnt_d       = CNT_INIT;
          state_d     = SINGLE ? RESP : WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        if (rspReady) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == IDLE);
  end

  // State and request registers; ready stays low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= 4'd0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
    end
  end

  assign reqReady = rdy_q;
  assign rspValid = (state_q == RESP);
  assign rspErr   = rspValid && err_q;
  assign rspRdata = (rspValid && !err_q && !req_q.wen) ? arr_rdata_s : 32'h0000_0000;

endmodule

// File: tb/tb_dmem_hs.sv
// Directed bench for dmem_hs: one instance with LATENCY=1, one with LATENCY=4.
module tb_dmem_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_wen   [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  dmem_hs #(.DEPTH_WORDS(16), .LATENCY(1), .BASE_ADDR(32'h0000_0000)) u_dut_l1 (
    .clk(clk), .rst(rst),
    .reqValid(req_valid[0]), .reqReady(req_ready[0]), .reqAddr(req_addr[0]),
    .reqWen(req_wen[0]), .reqWdata(req_wdata[0]), .reqBe(req_be[0]),
    .rspValid(rsp_valid[0]), .rspReady(rsp_ready[0]), .rspRdata(rsp_rdata[0]),
    .rspErr(rsp_err[0])
  );

  dmem_hs #(.DEPTH_WORDS(16), .LATENCY(4), .BASE_ADDR(32'h0000_0000)) u_dut_l4 (
    .clk(clk), .rst(rst),
    .reqValid(req_valid[1]), .reqReady(req_ready[1]), .reqAddr(req_addr[1]),
    .reqWen(req_wen[1]), .reqWdata(req_wdata[1]), .reqBe(req_be[1]),
    .rspValid(rsp_valid[1]), .rspReady(rsp_ready[1]), .rspRdata(rsp_rdata[1]),
    .rspErr(rsp_err[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic xact(input int d, input string tag, input logic [31:0] addr, input logic wen,
                      input logic [31:0] wdata, input logic [3:0] be,
                      input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    int lat;
    int wait_n;
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_addr[d]  = addr;
    req_wen[d]   = wen;
    req_wdata[d] = wdata;
    req_be[d]    = be;
    rsp_ready[d] = 1'b1;
    wait_n = 0;
    while (req_ready[d] !== 1'b1 && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    check({tag, "_acc"}, 32'(req_ready[d]), 32'd1);
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (rsp_valid[d] !== 1'b1 && lat < 20);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_err"}, 32'(rsp_err[d]), 32'(exp_err));
    check({tag, "_rdata"}, rsp_rdata[d], exp_rdata);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      req_wen[d]   = 1'b0;
      req_addr[d]  = 32'h0;
      req_wdata[d] = 32'h0;
      req_be[d]    = 4'h0;
      rsp_ready[d] = 1'b1;
    end
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    for (int d = 0; d < 2; d++) begin
      check("rst_req_ready", 32'(req_ready[d]), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      check("rst_rsp_rdata", rsp_rdata[d], 32'd0);
      check("rst_rsp_err", 32'(rsp_err[d]), 32'd0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) check("post_rst_ready", 32'(req_ready[d]), 32'd1);

    // LATENCY=1 basic store/load and byte lanes
    xact(0, "st_dead", 32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 1);
    xact(0, "ld_dead", 32'h10, 1'b0, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 1);
    xact(0, "st_1122", 32'h20, 1'b1, 32'h11223344, 4'hF, 32'h0, 1'b0, 1);
    xact(0, "st_lane1", 32'h20, 1'b1, 32'h0000AA00, 4'b0010, 32'h0, 1'b0, 1);
    xact(0, "ld_lane1", 32'h20, 1'b0, 32'h0, 4'hF, 32'h1122AA44, 1'b0, 1);

    // Faults
    xact(0, "st_w0", 32'h00, 1'b1, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0, 1);
    xact(0, "ld_mis", 32'h13, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1, 1);
    xact(0, "st_oor", 32'h40, 1'b1, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 1);
    xact(0, "ld_w0a", 32'h00, 1'b0, 32'h0, 4'hF, 32'hA5A5A5A5, 1'b0, 1);
    xact(0, "st_be0", 32'h00, 1'b1, 32'h00000000, 4'h0, 32'h0, 1'b1, 1);
    xact(0, "ld_w0b", 32'h00, 1'b0, 32'h0, 4'hF, 32'hA5A5A5A5, 1'b0, 1);
    xact(0, "ld_oor", 32'h40, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1, 1);

    // Response backpressure
    @(negedge clk);
    req_valid[0] = 1'b1; req_addr[0] = 32'h10; req_wen[0] = 1'b0; req_be[0] = 4'hF;
    rsp_ready[0] = 1'b0;
    check("bp_ready", 32'(req_ready[0]), 32'd1);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("bp_valid", 32'(rsp_valid[0]), 32'd1);
      check("bp_rdata", rsp_rdata[0], 32'hDEADBEEF);
      check("bp_err", 32'(rsp_err[0]), 32'd0);
      check("bp_noready", 32'(req_ready[0]), 32'd0);
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_done_valid", 32'(rsp_valid[0]), 32'd0);
    check("bp_done_ready", 32'(req_ready[0]), 32'd1);

    // LATENCY=4 timing and a request held across the busy window
    xact(1, "l4_st", 32'h30, 1'b1, 32'h12345678, 4'hF, 32'h0, 1'b0, 4);
    @(negedge clk);
    req_valid[1] = 1'b1; req_addr[1] = 32'h30; req_wen[1] = 1'b0; req_be[1] = 4'hF;
    rsp_ready[1] = 1'b1;
    check("l4_win_rdy0", 32'(req_ready[1]), 32'd1);
    @(posedge clk);
    #1;
    req_addr[1] = 32'h34; req_wen[1] = 1'b1; req_wdata[1] = 32'h0BADF00D; req_be[1] = 4'hF;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("l4_win_ready", 32'(req_ready[1]), 32'd0);
      check("l4_win_valid", 32'(rsp_valid[1]), 32'd0);
    end
    @(negedge clk);
    check("l4_rsp_valid", 32'(rsp_valid[1]), 32'd1);
    check("l4_rsp_ready", 32'(req_ready[1]), 32'd0);
    check("l4_rsp_rdata", rsp_rdata[1], 32'h12345678);
    @(negedge clk);
    check("l4_2nd_ready", 32'(req_ready[1]), 32'd1);
    check("l4_2nd_valid", 32'(rsp_valid[1]), 32'd0);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("l4_2nd_wait", 32'(rsp_valid[1]), 32'd0);
    end
    @(negedge clk);
    check("l4_2nd_rsp", 32'(rsp_valid[1]), 32'd1);
    check("l4_2nd_err", 32'(rsp_err[1]), 32'd0);
    @(posedge clk);
    #1;
    xact(1, "l4_ld34", 32'h34, 1'b0, 32'h0, 4'hF, 32'h0BADF00D, 1'b0, 4);

    // Reset during WAIT aborts the pending store
    @(negedge clk);
    req_valid[1] = 1'b1; req_addr[1] = 32'h30; req_wen[1] = 1'b1;
    req_wdata[1] = 32'hCAFEF00D; req_be[1] = 4'hF;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rsp_valid[1]), 32'd0);
    check("mid_rst_rdata", rsp_rdata[1], 32'd0);
    check("mid_rst_err", 32'(rsp_err[1]), 32'd0);
    check("mid_rst_ready", 32'(req_ready[1]), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_rst_hold", 32'(rsp_valid[1]), 32'd0);
    rst = 1'b1;
    xact(1, "l4_ld_abort", 32'h30, 1'b0, 32'h0, 4'hF, 32'h12345678, 1'b0, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
